// File: rtl/ethernet_tx_queue_mc_if.sv
// AXI-Stream TX bundle between the frame queue and the MAC FIFO.
// master drives data/keep/valid/last/user, slave returns ready.
interface ethernet_tx_queue_mc_if #(
  parameter int data_width_p = 64
);
  logic [data_width_p-1:0]   tdata;
  logic [data_width_p/8-1:0] tkeep;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic                      tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/ethernet_tx_queue_mc.sv
// Multi-channel MMIO-to-AXIS TX frame queue, round-robin arbitrated.
// Define ETH_TX_QUEUE_PAD_EN to zero-pad short frames to 60 bytes.
module ethernet_tx_queue_mc #(
  parameter int channels_p    = 2,
  parameter int data_width_p  = 64,
  parameter int depth_words_p = 256,
  localparam int len_width_p  =
    $clog2(depth_words_p*data_width_p/8)+1,
  localparam int ch_w_lp      =
    (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [channels_p-1:0]     data_v_i,
  input  logic [data_width_p-1:0]   data_i,
  output logic [channels_p-1:0]     data_yumi_o,
  input  logic [channels_p-1:0]     send_v_i,
  input  logic [len_width_p-1:0]    send_len_i,
  output logic [channels_p-1:0]     send_yumi_o,
  output logic [2*channels_p-1:0]   status_o,
  output logic [channels_p-1:0]     err_o,
  ethernet_tx_queue_mc_if.master    tx_axis,
  output logic                      sent_v_o,
  output logic [ch_w_lp-1:0]        sent_ch_o
);

  localparam int bytes_lp = data_width_p/8;
  localparam int kb_lp    = $clog2(bytes_lp);
  localparam int aw_lp    = $clog2(depth_words_p);
  localparam int pw_lp    = aw_lp + 1;
  localparam int el_w_lp  = (len_width_p > 7) ? len_width_p : 7;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    READY = 2'd1,
    SEND  = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [data_width_p-1:0] d;
    logic [bytes_lp-1:0]     k;
    logic                    l;
  } beat_t;

  ch_state_e              st_q   [channels_p];
  ch_state_e              st_n   [channels_p];
  logic [pw_lp-1:0]       wptr_q [channels_p];
  logic [pw_lp-1:0]       wptr_n [channels_p];
  logic [len_width_p-1:0] len_q  [channels_p];
  logic [len_width_p-1:0] len_n  [channels_p];
  logic [channels_p-1:0]  err_q, err_n;

  logic                   act_q;
  logic [ch_w_lp-1:0]     cur_q, last_q;
  logic [el_w_lp-1:0]     elen_q, rbeat_q;
  logic                   gnt_v;
  logic [ch_w_lp-1:0]     gnt_ch;
  logic                   pop, fin, issue, room;
  logic [el_w_lp-1:0]     rd_elen, rd_beat;
  logic [el_w_lp:0]       nb;
  logic                   rd_last;
  logic [bytes_lp-1:0]    rd_keep;
  logic                   p_v, p_l;
  logic [ch_w_lp-1:0]     p_ch;
  logic [bytes_lp-1:0]    p_k;
  logic [channels_p-1:0][data_width_p-1:0] rq_all;
  beat_t                  in_b, out_q, sk_q;
  logic                   out_v, sk_v;
`ifdef ETH_TX_QUEUE_PAD_EN
  logic [len_width_p-1:0] olen_q, rd_olen;
  logic [bytes_lp-1:0]    rd_zero, p_zero;
`endif

  function automatic logic [el_w_lp-1:0] eff_len(
    input logic [len_width_p-1:0] l
  );
`ifdef ETH_TX_QUEUE_PAD_EN
    return (int'(l) < 60) ? el_w_lp'(60) : el_w_lp'(l);
`else
    return el_w_lp'(l);
`endif
  endfunction

  assign pop = out_v & tx_axis.tready;
  assign fin = pop & out_q.l;

  for (genvar c = 0; c < channels_p; c++) begin : g_ch
    logic [data_width_p-1:0] mem [depth_words_p];
    logic [data_width_p-1:0] rq;
    always_ff @(posedge clk_i) begin
      if (data_yumi_o[c]) mem[wptr_q[c][aw_lp-1:0]] <= data_i;
      rq <= mem[rd_beat[aw_lp-1:0]];
    end
    assign rq_all[c]          = rq;
    assign status_o[2*c +: 2] = st_q[c];
  end

  always_comb begin
    logic [pw_lp-1:0]     wc;
    logic [len_width_p:0] cap;
    logic                 dy;
    wc          = '0;
    cap         = '0;
    dy          = 1'b0;
    data_yumi_o = '0;
    send_yumi_o = '0;
    err_n       = err_q;
    for (int c = 0; c < channels_p; c++) begin
      st_n[c]   = st_q[c];
      wptr_n[c] = wptr_q[c];
      len_n[c]  = len_q[c];
      unique case (st_q[c])
        FILL: begin
          dy  = reset_n_i && data_v_i[c] &&
                (int'(wptr_q[c]) < depth_words_p);
          wc  = wptr_q[c] + pw_lp'(dy);
          cap = (len_width_p+1)'(wc) << kb_lp;
          data_yumi_o[c] = dy;
          if (dy) wptr_n[c] = wc;
          if (reset_n_i && send_v_i[c]) begin
            send_yumi_o[c] = 1'b1;
            if (send_len_i != '0 && {1'b0, send_len_i} <= cap) begin
              st_n[c]  = READY;
              len_n[c] = send_len_i;
              err_n[c] = 1'b0;
            end else begin
              wptr_n[c] = '0;
              err_n[c]  = 1'b1;
            end
          end
        end
        READY: if (gnt_v && gnt_ch == ch_w_lp'(c)) st_n[c] = SEND;
        SEND: begin
          if (fin && cur_q == ch_w_lp'(c)) begin
            st_n[c]   = FILL;
            wptr_n[c] = '0;
          end
        end
        default: st_n[c] = FILL;
      endcase
    end
  end

  // Search starts one past the last grant so every channel gets a turn.
  always_comb begin
    int idx;
    idx    = 0;
    gnt_v  = 1'b0;
    gnt_ch = last_q;
    for (int i = 1; i <= channels_p; i++) begin
      idx = (int'(last_q) + i) % channels_p;
      if (!act_q && !gnt_v && st_q[ch_w_lp'(idx)] == READY) begin
        gnt_v  = 1'b1;
        gnt_ch = ch_w_lp'(idx);
      end
    end
  end

  always_comb begin
    int occ;
    rd_elen = gnt_v ? eff_len(len_q[gnt_ch]) : elen_q;
    rd_beat = gnt_v ? '0 : rbeat_q;
    nb      = ({1'b0, rd_elen} + (el_w_lp+1)'(bytes_lp-1)) >> kb_lp;
    rd_last = ({1'b0, rd_beat} + (el_w_lp+1)'(1)) == nb;
    for (int j = 0; j < bytes_lp; j++)
      rd_keep[j] = !rd_last || rd_elen[kb_lp-1:0] == '0 ||
                   j < int'(rd_elen[kb_lp-1:0]);
    occ   = int'(out_v) + int'(sk_v) + int'(p_v);
    room  = occ < 2 || pop;
    issue = gnt_v ||
            (act_q && {1'b0, rbeat_q} < nb && room);
`ifdef ETH_TX_QUEUE_PAD_EN
    rd_olen = gnt_v ? len_q[gnt_ch] : olen_q;
    for (int j = 0; j < bytes_lp; j++)
      rd_zero[j] = int'(rd_beat)*bytes_lp + j >= int'(rd_olen);
`endif
  end

  always_comb begin
    in_b.d = rq_all[p_ch];
    in_b.k = p_k;
    in_b.l = p_l;
`ifdef ETH_TX_QUEUE_PAD_EN
    for (int j = 0; j < bytes_lp; j++)
      if (p_zero[j]) in_b.d[8*j +: 8] = 8'h00;
`endif
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int c = 0; c < channels_p; c++) begin
        st_q[c]   <= FILL;
        wptr_q[c] <= '0;
        len_q[c]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int c = 0; c < channels_p; c++) begin
        st_q[c]   <= st_n[c];
        wptr_q[c] <= wptr_n[c];
        len_q[c]  <= len_n[c];
      end
      err_q <= err_n;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      act_q     <= 1'b0;
      cur_q     <= '0;
      last_q    <= '0;
      elen_q    <= '0;
      rbeat_q   <= '0;
      p_v       <= 1'b0;
      p_ch      <= '0;
      p_k       <= '0;
      p_l       <= 1'b0;
      sent_v_o  <= 1'b0;
      sent_ch_o <= '0;
`ifdef ETH_TX_QUEUE_PAD_EN
      olen_q    <= '0;
      p_zero    <= '0;
`endif
    end else begin
      if (gnt_v) begin
        act_q   <= 1'b1;
        cur_q   <= gnt_ch;
        last_q  <= gnt_ch;
        elen_q  <= rd_elen;
        rbeat_q <= el_w_lp'(1);
      end else begin
        if (issue) rbeat_q <= rbeat_q + el_w_lp'(1);
        if (fin) act_q <= 1'b0;
      end
      p_v       <= issue;
      p_ch      <= gnt_v ? gnt_ch : cur_q;
      p_k       <= rd_keep;
      p_l       <= rd_last;
      sent_v_o  <= fin;
      if (fin) sent_ch_o <= cur_q;
`ifdef ETH_TX_QUEUE_PAD_EN
      if (gnt_v) olen_q <= rd_olen;
      p_zero <= rd_zero;
`endif
    end
  end

  // Two-entry skid: out_q faces the MAC, sk_q absorbs one beat of stall.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v <= 1'b0;
      sk_v  <= 1'b0;
      out_q <= '0;
      sk_q  <= '0;
    end else if (pop) begin
      if (sk_v) begin
        out_q <= sk_q;
        if (p_v) sk_q <= in_b;
        else sk_v <= 1'b0;
      end else if (p_v) begin
        out_q <= in_b;
      end else begin
        out_v <= 1'b0;
        out_q <= '0;
      end
    end else if (p_v) begin
      if (!out_v) begin
        out_v <= 1'b1;
        out_q <= in_b;
      end else begin
        sk_v <= 1'b1;
        sk_q <= in_b;
      end
    end
  end

  assign tx_axis.tdata  = out_q.d;
  assign tx_axis.tkeep  = out_q.k;
  assign tx_axis.tlast  = out_q.l;
  assign tx_axis.tvalid = out_v;
  assign tx_axis.tuser  = 1'b0;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ethernet_tx_queue_mc.sv
// Randomized bench for ethernet_tx_queue_mc against a byte-level
// frame model; also covers directed length, full and arbitration cases.
module tb_ethernet_tx_queue_mc;
  localparam int CH = 2;
  localparam int W  = 64;
  localparam int D  = 8;
  localparam int B  = W/8;
  localparam int LW = $clog2(D*B)+1;

  logic          clk, rst_n;
  logic [CH-1:0] data_v, data_yumi, send_v, send_yumi, err;
  logic [W-1:0]  data;
  logic [LW-1:0] send_len;
  logic [2*CH-1:0] status;
  logic          sent_v;
  logic [0:0]    sent_ch;

  ethernet_tx_queue_mc_if #(.data_width_p(W)) axis ();

  ethernet_tx_queue_mc #(
    .channels_p(CH), .data_width_p(W), .depth_words_p(D)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .data_v_i(data_v), .data_i(data), .data_yumi_o(data_yumi),
    .send_v_i(send_v), .send_len_i(send_len), .send_yumi_o(send_yumi),
    .status_o(status), .err_o(err), .tx_axis(axis),
    .sent_v_o(sent_v), .sent_ch_o(sent_ch)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model
  int         m_cnt  [CH];
  bit         m_busy [CH];
  bit         m_err  [CH];
  logic [W-1:0] m_words [CH][D];
  logic [7:0] exp_b  [CH][64];
  int         exp_len[CH];
  int         sent_order[$];
  logic [W-1:0] obs_d[$];
  logic [B-1:0] obs_k[$];
  int         hs_cnt = 0;
  bit         mon_en = 0;
  int         rdy_mode = 2;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: axis.tready = ($urandom_range(0, 3) != 0);
        1: axis.tready = ~axis.tready;
        2: axis.tready = 1'b1;
        default: axis.tready = 1'b0;
      endcase
    end
  end

  // monitor: collects beats, checks stall stability, gap and frames
  initial begin
    logic pv, pr, pl, plhs;
    logic [W-1:0] pd;
    logic [B-1:0] pk;
    pv = 0; pr = 0; pl = 0; plhs = 0; pd = '0; pk = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        pv = 0; plhs = 0;
        continue;
      end
      if (pv && !pr) begin
        chk("stall_valid", axis.tvalid, 1);
        chk("stall_data", axis.tdata, pd);
        chk("stall_keep", axis.tkeep, pk);
        chk("stall_last", axis.tlast, pl);
      end
      if (plhs) chk("frame_gap", axis.tvalid, 0);
      plhs = axis.tvalid && axis.tready && axis.tlast;
      if (axis.tvalid && axis.tready) begin
        obs_d.push_back(axis.tdata);
        obs_k.push_back(axis.tkeep);
        hs_cnt++;
      end
      if (sent_v) begin
        int c, nb, r;
        logic [W-1:0] ew, em;
        logic [B-1:0] ek;
        c  = int'(sent_ch);
        chk("sent_busy", m_busy[c], 1);
        nb = (exp_len[c] + B - 1) / B;
        chk("beats", obs_d.size(), nb);
        for (int b = 0; b < obs_d.size() && b < nb; b++) begin
          r = exp_len[c] - b*B;
          ek = '0; ew = '0; em = '0;
          for (int j = 0; j < B; j++)
            if (j < r) begin
              ek[j] = 1'b1;
              ew[8*j +: 8] = exp_b[c][b*B+j];
              em[8*j +: 8] = 8'hff;
            end
          chk("tkeep", obs_k[b], ek);
          chk("tdata", obs_d[b] & em, ew);
        end
        obs_d.delete();
        obs_k.delete();
        m_busy[c] = 0;
        m_cnt[c]  = 0;
        sent_order.push_back(c);
      end
      pv = axis.tvalid; pr = axis.tready; pl = axis.tlast;
      pd = axis.tdata;  pk = axis.tkeep;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic bit busy_any();
    for (int c = 0; c < CH; c++) if (m_busy[c]) return 1;
    return 0;
  endfunction

  task automatic build_exp(input int c, input int len);
    int el;
    el = len;
`ifdef ETH_TX_QUEUE_PAD_EN
    if (el < 60) el = 60;
`endif
    for (int i = 0; i < 64; i++)
      exp_b[c][i] = (i < len) ? m_words[c][i/B][8*(i%B) +: 8] : 8'h00;
    exp_len[c] = el;
  endtask

  task automatic op(input logic [CH-1:0] dv, input logic [W-1:0] w,
                    input logic [CH-1:0] sv, input int len);
    bit bs [CH];
    bit ey, es;
    for (int c = 0; c < CH; c++) bs[c] = m_busy[c];
    data_v = dv; data = w; send_v = sv; send_len = LW'(len);
    @(negedge clk);
    for (int c = 0; c < CH; c++) begin
      ey = dv[c] && !bs[c] && m_cnt[c] < D;
      es = sv[c] && !bs[c];
      chk("data_yumi", data_yumi[c], ey);
      chk("send_yumi", send_yumi[c], es);
      if (ey) begin
        m_words[c][m_cnt[c]] = w;
        m_cnt[c]++;
      end
      if (es) begin
        if (len >= 1 && len <= m_cnt[c]*B) begin
          m_busy[c] = 1;
          m_err[c]  = 0;
          build_exp(c, len);
        end else begin
          m_err[c] = 1;
          m_cnt[c] = 0;
        end
      end
    end
    step();
    data_v = '0; send_v = '0;
    if (sv != '0) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++)
        if (sv[c] && !bs[c]) begin
          chk("err", err[c], m_err[c]);
          chk("status_busy", status[2*c +: 2] != 2'd0, m_busy[c]);
        end
      step();
    end
  endtask

  task automatic wr(input int c, input logic [W-1:0] w);
    logic [CH-1:0] m;
    m = '0; m[c] = 1'b1;
    op(m, w, '0, 0);
  endtask

  task automatic commit(input logic [CH-1:0] m, input int len);
    op('0, '0, m, len);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000 && busy_any(); i++) step();
    chk("drain_timeout", busy_any(), 0);
    repeat (3) step();
  endtask

  initial begin
    int n0, c, r, len, maxl;
    logic [CH-1:0] m;
    rst_n = 0; data_v = '1; send_v = '1; data = '1; send_len = '1;
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_busy[i] = 0; m_err[i] = 0; exp_len[i] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_status", status, 0);
    chk("rst_err", err, 0);
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tlast", axis.tlast, 0);
    chk("rst_tkeep", axis.tkeep, 0);
    chk("rst_sent_v", sent_v, 0);
    chk("rst_data_yumi", data_yumi, 0);
    chk("rst_send_yumi", send_yumi, 0);
    data_v = '0; send_v = '0; data = '0; send_len = '0;
    rst_n = 1;
    step();
    mon_en = 1;

    // 13-byte frame on ch0, then a write while busy is refused
    rdy_mode = 2;
    wr(0, 64'h1122334455667788);
    wr(0, 64'h33445566778899aa);
    commit(2'b01, 13);
    wr(0, 64'hdeadbeefdeadbeef);
    chk("tuser", axis.tuser, 0);
    wait_idle();

    // make ch1 the last grant, then both ready together
    wr(1, 64'h0102030405060708);
    commit(2'b10, 8);
    wait_idle();
    wr(0, 64'hA0A1A2A3A4A5A6A7);
    wr(1, 64'hB0B1B2B3B4B5B6B7);
    commit(2'b11, 5);
    wait_idle();
    chk("rr_first", sent_order[sent_order.size()-2], 0);
    chk("rr_second", sent_order[sent_order.size()-1], 1);

    // full buffer, overflow write, 8 beats under toggling ready
    rdy_mode = 1;
    for (int i = 0; i < D; i++) wr(0, {$urandom, $urandom});
    wr(0, 64'hFFFF_0000_FFFF_0000);
    commit(2'b01, D*B);
    wait_idle();

    // bad lengths discard the frame and raise err
    rdy_mode = 2;
    n0 = hs_cnt;
    commit(2'b10, 0);
    wr(1, 64'h1111);
    wr(1, 64'h2222);
    commit(2'b10, 17);
    repeat (5) step();
    chk("bad_len_no_traffic", hs_cnt - n0, 0);
    chk("bad_len_status", status[3:2], 0);
    wr(1, 64'h5555_6666_7777_8888);
    op(2'b10, 64'h9999_AAAA_BBBB_CCCC, 2'b10, 16);
    chk("err_cleared", err[1], 0);
    wait_idle();

    // randomized traffic
    rdy_mode = 0;
    for (int it = 0; it < 300; it++) begin
      c = $urandom_range(0, CH-1);
      if (m_busy[c]) begin
        step();
        continue;
      end
      r = $urandom_range(0, 99);
      if (r < 60 && m_cnt[c] < D) begin
        m = '0; m[c] = 1'b1;
        for (int o = 0; o < CH; o++)
          if (o != c && !m_busy[o] && $urandom_range(0, 3) == 0)
            m[o] = 1'b1;
        op(m, {$urandom, $urandom}, '0, 0);
      end else begin
        maxl = m_cnt[c]*B;
        if (maxl > 0 && $urandom_range(0, 4) != 0)
          len = $urandom_range(1, maxl);
        else
          len = (r % 2 == 1) ? 0 : maxl + $urandom_range(1, 20);
        m = '0; m[c] = 1'b1;
        commit(m, len);
      end
    end
    wait_idle();
    for (int i = 0; i < CH; i++) chk("final_err", err[i], m_err[i]);

    // reset mid-frame with the sink stalled
    rdy_mode = 3;
    wr(0, 64'h0F0E0D0C0B0A0908);
    commit(2'b01, 8);
    for (int i = 0; i < 20 && !axis.tvalid; i++) step();
    chk("stall_tvalid_up", axis.tvalid, 1);
    mon_en = 0;
    #2 rst_n = 0;
    #1 chk("async_tvalid_drop", axis.tvalid, 0);
    chk("async_status", status, 0);
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_busy[i] = 0; m_err[i] = 0;
    end
    obs_d.delete();
    obs_k.delete();
    @(negedge clk);
    rst_n = 1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
